// File: rtl/mem_wb_stage_pkg.sv
// +----------------------------------------------------------------------+
// | mem_wb_stage_pkg : shared pipeline encodings and width defaults      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_wb_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ADDR = 5;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_data_memory.sv
// +----------------------------------------------------------------------+
// | data_memory : byte-lane write-enabled RAM, async word + debug reads  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module data_memory #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clk,
  input  logic [NB_DATA/8-1:0]   i_we,
  input  logic [NB_MEM_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0]     i_wdata,
  output logic [NB_DATA-1:0]     o_rdata,
  input  logic [NB_MEM_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]     o_dbg_data
);

  localparam int NB_LANES = NB_DATA / 8;
  localparam int DEPTH    = 2 ** NB_MEM_ADDR;

  // One independent byte array per lane so partial stores touch only their lanes.
  generate
    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_we[l]) begin
          r_mem[i_addr] <= i_wdata[8*l +: 8];
        end
      end

      assign o_rdata[8*l +: 8]    = r_mem[i_addr];
      assign o_dbg_data[8*l +: 8] = r_mem[i_dbg_addr];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// +----------------------------------------------------------------------+
// | mem_wb_stage : MIPS MEM stage merged with the MEM/WB register        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int NB_DATA     = DEF_NB_DATA,
  parameter int NB_ADDR     = DEF_NB_ADDR,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [NB_DATA-1:0]     i_ALUresult,
  input  logic [NB_DATA-1:0]     i_store_data,
  input  logic [NB_ADDR-1:0]     i_reg2write,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [1:0]             i_size,
  input  logic                   i_unsigned,
  input  logic                   i_mem2reg,
  input  logic                   i_regWrite,
  input  logic [NB_MEM_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]     o_reg_read,
  output logic [NB_DATA-1:0]     o_ALUresult,
  output logic [NB_ADDR-1:0]     o_reg2write,
  output logic                   o_mem2reg,
  output logic                   o_regWrite,
  output logic                   o_align_err,
  output logic [NB_DATA-1:0]     o_dbg_data
);

  localparam int NB_LANES = NB_DATA / 8;

  logic [NB_MEM_ADDR+1:0] w_byte_addr;
  logic [NB_MEM_ADDR-1:0] w_word_idx;
  logic [1:0]             w_lane;
  logic                   w_aligned;
  logic                   w_misalign;
  logic                   w_store;
  logic [NB_LANES-1:0]    w_lane_mask;
  logic [NB_LANES-1:0]    w_we;
  logic [NB_DATA-1:0]     w_wdata;
  logic [NB_DATA-1:0]     w_rd_word;
  logic [7:0]             w_rd_byte;
  logic [15:0]            w_rd_half;
  logic [NB_DATA-1:0]     w_load_ext;

  logic [NB_DATA-1:0]     r_reg_read;
  logic [NB_DATA-1:0]     r_alu_result;
  logic [NB_ADDR-1:0]     r_reg2write;
  logic                   r_mem2reg;
  logic                   r_reg_write;
  logic                   r_align_err;

  assign w_byte_addr = i_ALUresult[NB_MEM_ADDR+1:0];
  assign w_word_idx  = w_byte_addr[NB_MEM_ADDR+1:2];
  assign w_lane      = w_byte_addr[1:0];

  always_comb begin
    w_aligned   = 1'b0;
    w_lane_mask = '0;
    w_wdata     = i_store_data;
    case (i_size)
      SIZE_BYTE: begin
        w_aligned   = 1'b1;
        w_lane_mask = NB_LANES'(1) << w_lane;
        w_wdata     = {NB_LANES{i_store_data[7:0]}};
      end
      SIZE_HALF: begin
        w_aligned   = ~w_lane[0];
        w_lane_mask = w_lane[1] ? NB_LANES'(4'b1100) : NB_LANES'(4'b0011);
        w_wdata     = {(NB_LANES/2){i_store_data[15:0]}};
      end
      SIZE_WORD: begin
        w_aligned   = (w_lane == 2'b00);
        w_lane_mask = '1;
      end
      default: begin
        w_aligned   = 1'b0;
        w_lane_mask = '0;
      end
    endcase
  end

  assign w_misalign = (i_mem_read | i_mem_write) & ~w_aligned;
  assign w_store    = i_enable & i_mem_write & w_aligned;
  assign w_we       = w_store ? w_lane_mask : '0;

  data_memory #(
    .NB_DATA     (NB_DATA),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) u_data_memory (
    .i_clk      (i_clk),
    .i_we       (w_we),
    .i_addr     (w_word_idx),
    .i_wdata    (w_wdata),
    .o_rdata    (w_rd_word),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // Read is taken before the edge, so a simultaneous store returns old contents.
  assign w_rd_byte = w_rd_word[8*w_lane +: 8];
  assign w_rd_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load_ext = w_rd_word;
    case (i_size)
      SIZE_BYTE: w_load_ext = i_unsigned ? {{(NB_DATA-8){1'b0}}, w_rd_byte}
                                         : {{(NB_DATA-8){w_rd_byte[7]}}, w_rd_byte};
      SIZE_HALF: w_load_ext = i_unsigned ? {{(NB_DATA-16){1'b0}}, w_rd_half}
                                         : {{(NB_DATA-16){w_rd_half[15]}}, w_rd_half};
      default:   w_load_ext = w_rd_word;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_read   <= '0;
      r_alu_result <= '0;
      r_reg2write  <= '0;
      r_mem2reg    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_align_err  <= 1'b0;
    end else if (i_enable) begin
      r_reg_read   <= (i_mem_read & w_aligned) ? w_load_ext : '0;
      r_alu_result <= i_ALUresult;
      r_reg2write  <= i_reg2write;
      r_mem2reg    <= i_mem2reg;
      r_reg_write  <= i_regWrite & ~w_misalign;
      r_align_err  <= r_align_err | w_misalign;
    end
  end

  assign o_reg_read  = r_reg_read;
  assign o_ALUresult = r_alu_result;
  assign o_reg2write = r_reg2write;
  assign o_mem2reg   = r_mem2reg;
  assign o_regWrite  = r_reg_write;
  assign o_align_err = r_align_err;

endmodule

`default_nettype wire
